// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker
//   Pops bytes from the ps2_keyboard byte FIFO and decodes set-2 scan code
//   sequences (make, F0 break, E0 extended, E0 F0 extended break). It keeps
//   a small table of currently held keys, separates typematic repeats from
//   new presses, tracks Shift/Caps and holds the last new press for display.
//
// Parameters
//   MAX_HELD : number of held-key table entries (1..8)
//   CNT_W    : width of the new-press counter
//
// Ports
//   clk        in   system clock
//   clrn       in   synchronous, active-high reset
//   data       in   byte at the head of the FIFO
//   ready      in   FIFO non-empty
//   overflow   in   FIFO overflow flag
//   nextdata_n out  active-low pop strobe, low for the cycle after a capture
//   evt_*      out  event strobe and fields (fields hold between strobes)
//   shift      out  either Shift key held
//   caps       out  Caps Lock toggle state
//   held_n     out  number of table entries in use
//   key_count  out  count of new (non-repeat) presses, wraps
//   disp_code  out  scan code of the last new press
//   disp_ascii out  ASCII of the last new press
//   disp_valid out  at least one key held
//   err        out  one-cycle protocol-error strobe
//   ovf_seen   out  sticky FIFO overflow indication
module ps2_key_tracker #(
  parameter int MAX_HELD = 4,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [7:0]                    data,
  input  logic                          ready,
  input  logic                          overflow,
  output logic                          nextdata_n,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic                          evt_repeat,
  output logic [7:0]                    evt_ascii,
  output logic                          shift,
  output logic                          caps,
  output logic [$clog2(MAX_HELD+1)-1:0] held_n,
  output logic [CNT_W-1:0]              key_count,
  output logic [7:0]                    disp_code,
  output logic [7:0]                    disp_ascii,
  output logic                          disp_valid,
  output logic                          err,
  output logic                          ovf_seen
);

  localparam int HN_W  = $clog2(MAX_HELD + 1);
  localparam int IDX_W = (MAX_HELD > 1) ? $clog2(MAX_HELD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } state_e;

  // Set-2 scan code to ASCII. Letters are lower case unless 'upper';
  // digits ignore case; extended codes never map.
  function automatic logic [7:0] ps2_ascii(input logic [7:0] code,
                                           input logic       ext,
                                           input logic       upper);
    logic [7:0] lc;
    logic [7:0] res;
    lc  = 8'h00;
    res = 8'h00;
    case (code)
      8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
      8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
      8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
      8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
      8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
      8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
      8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
      8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
      8'h45: res = 8'h30; 8'h16: res = 8'h31; 8'h1E: res = 8'h32;
      8'h26: res = 8'h33; 8'h25: res = 8'h34; 8'h2E: res = 8'h35;
      8'h36: res = 8'h36; 8'h3D: res = 8'h37; 8'h3E: res = 8'h38;
      8'h46: res = 8'h39;
      default: begin
        lc  = 8'h00;
        res = 8'h00;
      end
    endcase
    if (lc != 8'h00) res = upper ? (lc - 8'h20) : lc;
    if (ext) res = 8'h00;
    return res;
  endfunction

  state_e                    state_q, state_d;
  logic                      nd_q, nd_d;
  logic [MAX_HELD-1:0]       tbl_vld_q, tbl_vld_d;
  logic [MAX_HELD-1:0][8:0]  tbl_key_q, tbl_key_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      caps_q, caps_d;
  logic [7:0]                disp_code_q, disp_code_d;
  logic [7:0]                disp_ascii_q, disp_ascii_d;
  logic                      evt_valid_q, evt_valid_d;
  logic [7:0]                evt_code_q, evt_code_d;
  logic                      evt_ext_q, evt_ext_d;
  logic                      evt_break_q, evt_break_d;
  logic                      evt_repeat_q, evt_repeat_d;
  logic [7:0]                evt_ascii_q, evt_ascii_d;
  logic                      err_q, err_d;
  logic                      ovf_q, ovf_d;

  logic                      capture;
  logic                      is_make, is_break, is_ext, proto_err;
  logic [8:0]                key_in;
  logic                      hit, free_found, shift_w;
  logic [IDX_W-1:0]          hit_idx, free_idx;
  logic [HN_W-1:0]           held_cnt;
  logic [7:0]                ascii_now;

  // A byte is only taken while the pop strobe is idle, so the FIFO
  // always sees a full low cycle before the next capture.
  assign capture = ready & nd_q;
  assign nd_d    = ~capture;

  // Prefix decoder
  always_comb begin
    state_d   = state_q;
    is_make   = 1'b0;
    is_break  = 1'b0;
    is_ext    = 1'b0;
    proto_err = 1'b0;
    if (capture) begin
      case (state_q)
        S_IDLE: begin
          if (data == 8'hE0)      state_d = S_E0;
          else if (data == 8'hF0) state_d = S_F0;
          else                    is_make = 1'b1;
        end
        S_E0: begin
          state_d = S_IDLE;
          if (data == 8'hF0) begin
            state_d = S_E0F0;
          end else if (data == 8'hE0) begin
            proto_err = 1'b1;
          end else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
          end
        end
        S_F0: begin
          state_d = S_IDLE;
          if (data == 8'hE0 || data == 8'hF0) proto_err = 1'b1;
          else                                 is_break  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          if (data == 8'hE0 || data == 8'hF0) begin
            proto_err = 1'b1;
          end else begin
            is_break = 1'b1;
            is_ext   = 1'b1;
          end
        end
      endcase
    end
  end

  assign key_in = {is_ext, data};

  // Table search: match, lowest free slot, Shift presence and occupancy
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    shift_w    = 1'b0;
    held_cnt   = '0;
    for (int i = 0; i < MAX_HELD; i++) begin
      if (tbl_vld_q[i]) begin
        held_cnt = held_cnt + HN_W'(1);
        if (tbl_key_q[i] == 9'h012 || tbl_key_q[i] == 9'h059) shift_w = 1'b1;
        if (!hit && tbl_key_q[i] == key_in) begin
          hit     = 1'b1;
          hit_idx = IDX_W'(i);
        end
      end else if (!free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // ASCII is formed from the Shift/Caps state before this event lands.
  assign ascii_now = ps2_ascii(data, is_ext, shift_w ^ caps_q);

  // Event and held-state update
  always_comb begin
    tbl_vld_d    = tbl_vld_q;
    tbl_key_d    = tbl_key_q;
    cnt_d        = cnt_q;
    caps_d       = caps_q;
    disp_code_d  = disp_code_q;
    disp_ascii_d = disp_ascii_q;
    evt_valid_d  = 1'b0;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_break_d  = evt_break_q;
    evt_repeat_d = evt_repeat_q;
    evt_ascii_d  = evt_ascii_q;
    err_d        = proto_err;
    ovf_d        = ovf_q | overflow;

    if (is_make || is_break) begin
      evt_valid_d  = 1'b1;
      evt_code_d   = data;
      evt_ext_d    = is_ext;
      evt_break_d  = is_break;
      evt_repeat_d = is_make & hit;
      evt_ascii_d  = ascii_now;
    end

    // A new press counts and reaches the display even when the table is full.
    if (is_make && !hit) begin
      if (free_found) begin
        tbl_vld_d[free_idx] = 1'b1;
        tbl_key_d[free_idx] = key_in;
      end
      cnt_d        = cnt_q + CNT_W'(1);
      disp_code_d  = data;
      disp_ascii_d = ascii_now;
      if (key_in == 9'h058) caps_d = ~caps_q;
    end

    if (is_break && hit) tbl_vld_d[hit_idx] = 1'b0;
  end

  // Register stage
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_q      <= S_IDLE;
      nd_q         <= 1'b1;
      tbl_vld_q    <= '0;
      tbl_key_q    <= '0;
      cnt_q        <= '0;
      caps_q       <= 1'b0;
      disp_code_q  <= '0;
      disp_ascii_q <= '0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
      evt_ext_q    <= 1'b0;
      evt_break_q  <= 1'b0;
      evt_repeat_q <= 1'b0;
      evt_ascii_q  <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      nd_q         <= nd_d;
      tbl_vld_q    <= tbl_vld_d;
      tbl_key_q    <= tbl_key_d;
      cnt_q        <= cnt_d;
      caps_q       <= caps_d;
      disp_code_q  <= disp_code_d;
      disp_ascii_q <= disp_ascii_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_break_q  <= evt_break_d;
      evt_repeat_q <= evt_repeat_d;
      evt_ascii_q  <= evt_ascii_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign nextdata_n = nd_q;
  assign evt_valid  = evt_valid_q;
  assign evt_code   = evt_code_q;
  assign evt_ext    = evt_ext_q;
  assign evt_break  = evt_break_q;
  assign evt_repeat = evt_repeat_q;
  assign evt_ascii  = evt_ascii_q;
  assign shift      = shift_w;
  assign caps       = caps_q;
  assign held_n     = held_cnt;
  assign key_count  = cnt_q;
  assign disp_code  = disp_code_q;
  assign disp_ascii = disp_ascii_q;
  assign disp_valid = (held_cnt != '0);
  assign err        = err_q;
  assign ovf_seen   = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

  localparam int MH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clrn = 1'b1;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;
  logic [7:0] data = 8'h00;

  logic       nd, ev, eext, ebrk, erep, sh, cp, dv, er, ov;
  logic [7:0] ecode, easc, kc, dcode, dasc;
  logic [2:0] hn;

  logic       nd2, ev2, eext2, ebrk2, erep2, sh2, cp2, dv2, er2, ov2;
  logic [7:0] ecode2, easc2, kc2, dcode2, dasc2;
  logic [1:0] hn2;

  ps2_key_tracker #(.MAX_HELD(MH), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nd), .evt_valid(ev), .evt_code(ecode), .evt_ext(eext),
    .evt_break(ebrk), .evt_repeat(erep), .evt_ascii(easc), .shift(sh),
    .caps(cp), .held_n(hn), .key_count(kc), .disp_code(dcode),
    .disp_ascii(dasc), .disp_valid(dv), .err(er), .ovf_seen(ov)
  );

  // Second instance with a two-entry table, driven by the same inputs.
  ps2_key_tracker #(.MAX_HELD(2), .CNT_W(8)) dut2 (
    .clk(clk), .clrn(clrn), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nd2), .evt_valid(ev2), .evt_code(ecode2), .evt_ext(eext2),
    .evt_break(ebrk2), .evt_repeat(erep2), .evt_ascii(easc2), .shift(sh2),
    .caps(cp2), .held_n(hn2), .key_count(kc2), .disp_code(dcode2),
    .disp_ascii(dasc2), .disp_valid(dv2), .err(er2), .ovf_seen(ov2)
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus FIFO (emulates ps2_keyboard) ----------------
  logic [7:0] fifo[$];
  int         gate_pct = 100;

  initial forever begin
    @(negedge clk);
    if (fifo.size() > 0 && $urandom_range(99) < gate_pct) begin
      ready = 1'b1;
      data  = fifo[0];
    end else begin
      ready = 1'b0;
      data  = 8'($urandom);
    end
  end

  // ---------------- behavioural reference model ----------------
  logic [7:0] LETTERS[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                              8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                              8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                              8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] DIGITS[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                              8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit ext, input bit up);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == c) return (up ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == c) return 8'h30 + 8'(i);
    return 8'h00;
  endfunction

  bit         started = 0;
  logic [7:0] pre[$];
  bit         held[int];
  logic       m_nd, m_ev, m_ext, m_brk, m_rep, m_caps, m_err, m_ovf;
  logic [7:0] m_code, m_asc, m_kc, m_dcode, m_dasc;

  function automatic bit m_shift();
    return held.exists(32'h012) || held.exists(32'h059);
  endfunction

  task automatic model_reset();
    pre.delete(); held.delete();
    m_nd = 1; m_ev = 0; m_ext = 0; m_brk = 0; m_rep = 0; m_caps = 0; m_err = 0; m_ovf = 0;
    m_code = 0; m_asc = 0; m_kc = 0; m_dcode = 0; m_dasc = 0;
  endtask

  task automatic emit(input bit ext, input bit brk, input logic [7:0] c);
    int key;
    bit rep;
    key    = ext ? 256 + int'(c) : int'(c);
    rep    = !brk && held.exists(key);
    m_ev   = 1; m_code = c; m_ext = ext; m_brk = brk; m_rep = rep;
    m_asc  = ref_ascii(c, ext, m_shift() ^ m_caps);
    if (!brk && !rep) begin
      if (held.num() < MH) held[key] = 1;
      m_kc    = m_kc + 8'd1;
      m_dcode = c;
      m_dasc  = m_asc;
      if (key == 32'h058) m_caps = !m_caps;
    end
    if (brk && held.exists(key)) held.delete(key);
  endtask

  // Sequence-level decode: collect prefixes, then classify the whole sequence.
  task automatic apply_byte(input logic [7:0] b);
    int n;
    bit pfx;
    pre.push_back(b);
    n   = pre.size();
    pfx = (b == 8'hE0) || (b == 8'hF0);
    if (n == 1 && pfx) return;
    if (n == 2 && pre[0] == 8'hE0 && b == 8'hF0) return;
    if (!pfx) emit(pre[0] == 8'hE0, n >= 2 && pre[n-2] == 8'hF0, b);
    else m_err = 1;
    pre.delete();
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (clrn) begin
        model_reset();
        started = 1;
      end else begin
        bit cap;
        m_ev = 0;
        m_err = 0;
        if (overflow) m_ovf = 1;
        cap  = ready && m_nd;
        m_nd = !cap;
        if (cap) begin
          if (fifo.size() > 0) void'(fifo.pop_front());
          apply_byte(data);
        end
      end
    end
  end

  // ---------------- compare process and event monitor ----------------
  typedef struct {
    logic [7:0] code;
    logic       ext, brk, rep;
    logic [7:0] asc, kc;
    logic       dv;
    logic [2:0] hn;
  } ev_t;
  ev_t evlog[$];
  int  popcnt = 0;
  int  errmon = 0;

  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("nextdata_n", nd, m_nd);
      chk("evt_valid", ev, m_ev);
      chk("err", er, m_err);
      chk("evt_code", ecode, m_code);
      chk("evt_ext", eext, m_ext);
      chk("evt_break", ebrk, m_brk);
      chk("evt_repeat", erep, m_rep);
      chk("evt_ascii", easc, m_asc);
      chk("shift", sh, m_shift());
      chk("caps", cp, m_caps);
      chk("held_n", hn, held.num());
      chk("key_count", kc, m_kc);
      chk("disp_code", dcode, m_dcode);
      chk("disp_ascii", dasc, m_dasc);
      chk("disp_valid", dv, held.num() != 0);
      chk("ovf_seen", ov, m_ovf);
      if (ev === 1'b1) evlog.push_back('{ecode, eext, ebrk, erep, easc, kc, dv, hn});
      if (er === 1'b1) errmon++;
      if (nd === 1'b0) popcnt++;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk); clrn = 1'b1;
    @(negedge clk); clrn = 1'b0;
    evlog.delete(); popcnt = 0; errmon = 0;
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", fifo.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    clrn = 1'b0;

    // Reset state
    do_reset();
    chk("rst_nextdata_n", nd, 1);
    chk("rst_evt_valid", ev, 0);
    chk("rst_key_count", kc, 0);
    chk("rst_held_n", hn, 0);
    chk("rst_ovf_seen", ov, 0);

    // Press and release 'a'
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain(200);
    chk("a_nevents", evlog.size(), 2);
    chk("a_ev0_code", evlog[0].code, 8'h1C);
    chk("a_ev0_break", evlog[0].brk, 0);
    chk("a_ev0_ascii", evlog[0].asc, 8'h61);
    chk("a_ev0_count", evlog[0].kc, 1);
    chk("a_ev1_break", evlog[1].brk, 1);
    chk("a_ev1_dvalid", evlog[1].dv, 0);
    chk("a_pops", popcnt, 3);

    // Shift + 'A' with typematic repeat
    do_reset();
    push(8'h12); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    push(8'hF0); push(8'h12);
    drain(200);
    chk("sh_nevents", evlog.size(), 5);
    chk("sh_ev1_ascii", evlog[1].asc, 8'h41);
    chk("sh_ev1_repeat", evlog[1].rep, 0);
    chk("sh_ev2_repeat", evlog[2].rep, 1);
    chk("sh_key_count", kc, 2);
    chk("sh_shift", sh, 0);
    chk("sh_held_n", hn, 0);

    // Extended key press/release
    do_reset();
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain(200);
    chk("ext_nevents", evlog.size(), 2);
    chk("ext_ev0_ext", evlog[0].ext, 1);
    chk("ext_ev0_break", evlog[0].brk, 0);
    chk("ext_ev0_ascii", evlog[0].asc, 0);
    chk("ext_ev0_held", evlog[0].hn, 1);
    chk("ext_ev1_ext", evlog[1].ext, 1);
    chk("ext_ev1_break", evlog[1].brk, 1);
    chk("ext_ev1_held", evlog[1].hn, 0);

    // Full table on the two-entry instance
    do_reset();
    push(8'h15); push(8'h1D); push(8'h24);
    drain(200);
    chk("full2_held_n", hn2, 2);
    chk("full2_key_count", kc2, 3);
    chk("full2_disp_code", dcode2, 8'h24);
    chk("full4_held_n", hn, 3);
    push(8'hF0); push(8'h24);
    drain(200);
    chk("full2_held_after_rel", hn2, 2);
    chk("full4_held_after_rel", hn, 2);

    // Caps Lock
    do_reset();
    push(8'h58); push(8'hF0); push(8'h58); push(8'h1C);
    drain(200);
    chk("caps_on", cp, 1);
    chk("caps_nevents", evlog.size(), 3);
    chk("caps_ascii", evlog[2].asc, 8'h41);

    // Protocol error
    do_reset();
    push(8'hF0); push(8'hF0); push(8'h1C);
    drain(200);
    chk("perr_strobes", errmon, 1);
    chk("perr_nevents", evlog.size(), 1);
    chk("perr_code", evlog[0].code, 8'h1C);
    chk("perr_break", evlog[0].brk, 0);

    // Reset discards a pending E0
    do_reset();
    push(8'hE0);
    drain(200);
    do_reset();
    push(8'h75);
    drain(200);
    chk("rstpfx_nevents", evlog.size(), 1);
    chk("rstpfx_code", evlog[0].code, 8'h75);
    chk("rstpfx_ext", evlog[0].ext, 0);

    // Overflow stickiness and counter wrap
    do_reset();
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    @(negedge clk);
    chk("ovf_set", ov, 1);
    for (int i = 0; i < 255; i++) begin
      push(8'h1C); push(8'hF0); push(8'h1C);
    end
    drain(5000);
    chk("wrap_ff", kc, 8'hFF);
    chk("ovf_still_set", ov, 1);
    push(8'h1C);
    drain(200);
    chk("wrap_00", kc, 8'h00);
    do_reset();
    chk("ovf_cleared", ov, 0);

    // Randomized traffic with gated ready, overflow pulses and mid-stream resets
    gate_pct = 70;
    for (int it = 0; it < 40; it++) begin
      for (int j = 0; j < 15; j++) begin
        int sel;
        sel = $urandom_range(15);
        case (sel)
          0, 1:    push(8'hE0);
          2, 3, 4: push(8'hF0);
          5:       push(8'h12);
          6:       push(8'h59);
          7:       push(8'h58);
          8:       push(8'h1C);
          9:       push(8'h1B);
          10:      push(8'h45);
          11:      push(8'h75);
          12:      push(8'h24);
          13:      push(8'h16);
          default: push(8'($urandom));
        endcase
      end
      repeat ($urandom_range(30)) @(negedge clk);
      if ($urandom_range(5) == 0) begin
        @(negedge clk); overflow = 1'b1;
        @(negedge clk); overflow = 1'b0;
      end
      if ($urandom_range(7) == 0) begin
        @(negedge clk); clrn = 1'b1;
        @(negedge clk); clrn = 1'b0;
      end
    end
    drain(5000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Parametrised scan-code decoder between `ps2_keyboard` (byte FIFO with `ready`/`nextdata_n`) and the seven-segment display logic. It pops bytes with the FIFO handshake and decodes make, break (`F0`) and extended (`E0`) sequences. It tracks up to `MAX_HELD` simultaneously held keys, suppresses typematic repeats from the press count, maintains Shift/Caps state, and emits one event per completed code plus held display registers.

## Interface
- `MAX_HELD`, 4, number of held-key table entries (1..8)
- `CNT_W`, 8, width of press counter
- `clk` in 1: system clock
- `clrn` in 1: reset; synchronous and active-high
- `data` in 8: byte at head of `ps2_keyboard` FIFO
- `ready` in 1: FIFO non-empty
- `overflow` in 1: FIFO overflow flag from `ps2_keyboard`
- `nextdata_n` out 1: active-low pop strobe to FIFO
- `evt_valid` out 1: one-cycle event strobe
- `evt_code` out 8: scan code of event (prefixes stripped)
- `evt_ext` out 1: event code was `E0`-prefixed
- `evt_break` out 1: 1 = release, 0 = press
- `evt_repeat` out 1: press of a key already held (typematic)
- `evt_ascii` out 8: ASCII of event key, 0 if unmapped
- `shift` out 1: either Shift held
- `caps` out 1: Caps Lock toggle state
- `held_n` out $clog2(MAX_HELD+1): number of table entries in use
- `key_count` out CNT_W: count of new (non-repeat) presses
- `disp_code`, `disp_ascii` out 8 each: last new press, held for display
- `disp_valid` out 1: at least one key held; display blanks when 0
- `err` out 1: one-cycle protocol-error strobe
- `ovf_seen` out 1: sticky, set when `overflow`=1

## Operation
- Pop: byte is captured on a cycle with `ready`=1 and `nextdata_n`=1. `nextdata_n`=0 on exactly the following cycle. No capture is allowed while `nextdata_n`=0, so the maximum rate is one byte per 2 cycles.
- Decoder FSM with states IDLE, E0, F0, E0F0 (transitions apply on each captured byte):
  - IDLE: `E0`→E0; `F0`→F0; other byte → make(ext=0), stay IDLE.
  - E0: `F0`→E0F0; `E0`→err, IDLE; other byte → make(ext=1), IDLE.
  - F0: `E0`/`F0`→err, IDLE; other byte → break(ext=0), IDLE.
  - E0F0: `E0`/`F0`→err, IDLE; other byte → break(ext=1), IDLE.
- Make, key {ext,code} already in table: event with `evt_repeat`=1. Table, `key_count`, `caps` and display registers are unchanged.
- Make, key not in table:
  - Insert the key into the lowest free slot and increment `key_count`; the counter wraps from all-ones to 0.
  - Load `disp_code`/`disp_ascii` with this key.
  - If the table is full, do not insert, but still increment the count, update the display and emit the event.
- Break: remove the matching entry if present. A break with no matching entry still emits an event and has no other effect.
- `shift` = table holds non-ext `12` or non-ext `59`.
- `caps` toggles on a new press of non-ext `58` only.
- ASCII mapping, for non-ext codes only; ext codes and all other codes give 0:
  - letters map per the PS/2 set-2 table to `61`..`7A`, subtracting `20` when `shift` XOR `caps`;
  - digits map per the PS/2 set-2 table to `30`..`39`, with no shift effect.
- `evt_ascii` uses the `shift`/`caps` values in effect before the event is applied.
- `disp_valid` = (`held_n` != 0). `disp_code`/`disp_ascii` keep their value while `disp_valid`=0.
- `ovf_seen` is set by `overflow`=1 and cleared only by `clrn`.

## Timing
- Byte captured in cycle t → in cycle t+1: `evt_valid`/`err` strobe, `nextdata_n`=0, and updated table, counters, `shift`, `caps` and display registers.
- `evt_*` fields are valid only while `evt_valid`=1; they hold their last value otherwise.
- Reset (`clrn`=1 at a clock edge):
  - FSM goes to IDLE and the table is emptied.
  - `nextdata_n`=1.
  - All other outputs are 0, including `key_count`, `caps` and `ovf_seen`.
  - Reset dominates a simultaneous capture; a byte pending in the FIFO is not popped.
- Reset in the middle of a sequence (e.g. after `E0`) discards the partial prefix.
- `ready` dropping while `nextdata_n`=0 is legal and has no effect.

## Test plan
- Bytes `1C`,`F0`,`1C` → `evt_valid` twice:
  - first event: `evt_code`=1C, `evt_break`=0, `evt_ascii`=61, `key_count`=1;
  - second event: `evt_break`=1, `disp_valid`=0;
  - `nextdata_n` low for one cycle after each byte, 3 pops total.
- Bytes `12`,`1C`,`1C`,`F0`,`1C`,`F0`,`12`:
  - first `1C` event: `evt_ascii`=41, `evt_repeat`=0;
  - second `1C` event: `evt_repeat`=1;
  - end state: `key_count`=2, `shift`=0, `held_n`=0.
- Bytes `E0`,`75`,`E0`,`F0`,`75` → events ext=1 press then ext=1 release; `evt_ascii`=0; `held_n` goes 1→0.
- `MAX_HELD`=2, press `15`,`1D`,`24` without releases → `held_n`=2, `key_count`=3, `disp_code`=24; release `24` → `held_n` stays 2.
- Bytes `58`,`F0`,`58`,`1C` → `caps`=1, `evt_ascii`=41.
- Protocol and reset cases:
  - Bytes `F0`,`F0`,`1C` → `err` strobe once, then a make event for `1C`.
  - `clrn` asserted after `E0` → next byte `75` decodes as make with ext=0.
  - `overflow` pulse → `ovf_seen`=1 until reset; `key_count` from 8'hFF wraps to 00 after one more new press.
